// File: rtl/pack_pkg.sv
// Shared constants and types for the pack frame parser
// and the reusable CRC step.
package pack_pkg;

  localparam logic [7:0] SYNC0 = 8'hEB;
  localparam logic [7:0] SYNC1 = 8'h90;

  localparam int HEAD_LEN = 14;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [1:0] ERR_CRC = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC2,
    ST_HEAD,
    ST_LOAD,
    ST_TAIL,
    ST_CRC
  } state_t;

endpackage

// File: rtl/pack_crc16_step.sv
// Byte-wise CRC-16/CCITT-FALSE update, purely combinational.
// crc_in: running CRC, data: next byte, crc_out: updated CRC.
module pack_crc16_step
  import pack_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/pack_parse.sv
// Receive-side pack frame parser: sync hunt, header latch,
// load/tail forwarding, CRC check, inter-byte timeout.
// In : clk_sys, rst, rx_data/rx_vld (byte stream, no backpressure)
// Out: ld_* load stream, tl_* tail stream, hd_* header fields + hd_vld,
//      pkt_ok / pkt_err + err_code status pulses, busy,
//      cnt_ok / cnt_err counters (built only with PACK_PARSE_CNT_EN).
module pack_parse
  import pack_pkg::*;
#(
  parameter logic [11:0] MAX_LOAD = 12'd3072,
  parameter int          TAIL_LEN = 36,
  parameter logic [15:0] GAP_MAX  = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  ld_data,
  output logic        ld_vld,
  output logic        ld_sop,
  output logic        ld_eop,
  output logic [7:0]  tl_data,
  output logic        tl_vld,
  output logic [7:0]  hd_dev_id,
  output logic [7:0]  hd_sample,
  output logic [11:0] hd_len,
  output logic [31:0] hd_utc,
  output logic [31:0] hd_ns,
  output logic        hd_vld,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  state_t state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [15:0] gap;
  logic [15:0] crc_q, crc_base, crc_step;
  logic [7:0]  crc_hi;

  logic [7:0]  s_dev, s_smp;
  logic [11:0] s_len;
  logic [31:0] s_utc, s_ns;

  logic tmo, acc;
  logic ld_go, ld_first, ld_last, tl_go;
  logic hd_go, ok_go, err_go;
  logic [1:0] code_go;
  logic crc_upd, crc_init;

  // Timeout wins over a byte arriving in the same cycle.
  assign tmo  = (state != ST_IDLE) && (gap == GAP_MAX);
  assign acc  = rx_vld && !tmo;
  assign busy = (state != ST_IDLE);

  // A fresh 0xEB always restarts the CRC from its seed.
  assign crc_base = crc_init ? CRC_INIT : crc_q;

  pack_crc16_step u_crc (
    .crc_in  (crc_base),
    .data    (rx_data),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_go     = 1'b0;
    ld_first  = 1'b0;
    ld_last   = 1'b0;
    tl_go     = 1'b0;
    hd_go     = 1'b0;
    ok_go     = 1'b0;
    err_go    = 1'b0;
    code_go   = ERR_CRC;
    crc_upd   = 1'b0;
    crc_init  = 1'b0;
    if (tmo) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      err_go    = 1'b1;
      code_go   = ERR_TMO;
    end else if (rx_vld) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == SYNC0) begin
            state_nxt = ST_SYNC2;
            crc_upd   = 1'b1;
            crc_init  = 1'b1;
          end
        end
        ST_SYNC2: begin
          if (rx_data == SYNC1) begin
            state_nxt = ST_HEAD;
            cnt_nxt   = '0;
            crc_upd   = 1'b1;
          end else if (rx_data == SYNC0) begin
            crc_upd  = 1'b1;
            crc_init = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_HEAD: begin
          crc_upd = 1'b1;
          if (cnt == 12'(HEAD_LEN - 3)) begin
            cnt_nxt = '0;
            if (s_len == 12'd0 || s_len > MAX_LOAD) begin
              state_nxt = ST_IDLE;
              err_go    = 1'b1;
              code_go   = ERR_LEN;
            end else begin
              state_nxt = ST_LOAD;
              hd_go     = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 12'd1;
          end
        end
        ST_LOAD: begin
          crc_upd  = 1'b1;
          ld_go    = 1'b1;
          ld_first = (cnt == 12'd0);
          if (cnt == s_len - 12'd1) begin
            ld_last   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_TAIL;
          end else begin
            cnt_nxt = cnt + 12'd1;
          end
        end
        ST_TAIL: begin
          crc_upd = 1'b1;
          tl_go   = 1'b1;
          if (cnt == 12'(TAIL_LEN - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_CRC;
          end else begin
            cnt_nxt = cnt + 12'd1;
          end
        end
        ST_CRC: begin
          if (cnt == 12'd0) begin
            cnt_nxt = 12'd1;
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
            if ({crc_hi, rx_data} == crc_q) begin
              ok_go = 1'b1;
            end else begin
              err_go  = 1'b1;
              code_go = ERR_CRC;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      gap <= '0;
    end else if (state == ST_IDLE || rx_vld || tmo) begin
      gap <= '0;
    end else begin
      gap <= gap + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      crc_q  <= CRC_INIT;
      crc_hi <= '0;
      s_dev  <= '0;
      s_smp  <= '0;
      s_len  <= '0;
      s_utc  <= '0;
      s_ns   <= '0;
    end else begin
      if (crc_upd) crc_q <= crc_step;
      if (acc && state == ST_CRC && cnt == 12'd0) crc_hi <= rx_data;
      if (acc && state == ST_HEAD) begin
        if (cnt == 12'd0)      s_dev <= rx_data;
        else if (cnt == 12'd1) s_smp <= rx_data;
        else if (cnt == 12'd2) s_len[11:8] <= rx_data[3:0];
        else if (cnt == 12'd3) s_len[7:0] <= rx_data;
        else if (cnt < 12'd8)  s_utc <= {s_utc[23:0], rx_data};
        else                   s_ns <= {s_ns[23:0], rx_data};
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ld_data   <= '0;
      ld_vld    <= 1'b0;
      ld_sop    <= 1'b0;
      ld_eop    <= 1'b0;
      tl_data   <= '0;
      tl_vld    <= 1'b0;
      hd_dev_id <= '0;
      hd_sample <= '0;
      hd_len    <= '0;
      hd_utc    <= '0;
      hd_ns     <= '0;
      hd_vld    <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      ld_vld  <= ld_go;
      ld_sop  <= ld_go && ld_first;
      ld_eop  <= ld_last;
      tl_vld  <= tl_go;
      hd_vld  <= hd_go;
      pkt_ok  <= ok_go;
      pkt_err <= err_go;
      err_code <= err_go ? code_go : 2'd0;
      if (ld_go) ld_data <= rx_data;
      if (tl_go) tl_data <= rx_data;
      if (hd_go) begin
        hd_dev_id <= s_dev;
        hd_sample <= s_smp;
        hd_len    <= s_len;
        hd_utc    <= s_utc;
        hd_ns     <= {s_ns[23:0], rx_data};
      end
    end
  end

`ifdef PACK_PARSE_CNT_EN
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else begin
      if (pkt_ok && cnt_ok != 16'hFFFF)   cnt_ok  <= cnt_ok + 16'd1;
      if (pkt_err && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
    end
  end
`else
  assign cnt_ok  = '0;
  assign cnt_err = '0;
`endif

endmodule
